// File: rtl/vga_scandoubler.sv
// vga_scandoubler: 15 kHz PAL RGB (3 bits/component) to 31 kHz VGA-rate
// scan doubler. Each input line is written into one bank of a ping-pong line
// buffer. Meanwhile the previously completed line is read out twice at the
// full clk rate.
//
// Optional feature macro: SCANDOUBLER_SCANLINES_EN. When it is defined, the
// second output copy of every line has each colour component halved, which
// gives a scanline look. Syncs are never affected.
//
// Valid/ready: this block has no handshake. ce_pix qualifies every input
// sample, and the outputs are a free-running registered stream.
module vga_scandoubler #(
  parameter int ADDR_W      = 9,
  parameter int DEFAULT_LEN = 448,
  parameter int HSYNC_W     = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce_pix,
  input  logic [2:0] ri,
  input  logic [2:0] gi,
  input  logic [2:0] bi,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [2:0] ro,
  output logic [2:0] go,
  output logic [2:0] bo,
  output logic       hsync,
  output logic       vsync
);

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] HW_MAX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LEN_RST = (ADDR_W + 1)'(DEFAULT_LEN);
  localparam logic [ADDR_W:0]   HS_LEN  = (ADDR_W + 1)'(HSYNC_W);

  // Two banks; the bank select is the top address bit.
  logic [8:0]        mem [2*DEPTH];

  logic              wbank;
  logic [ADDR_W-1:0] hw;
  logic [ADDR_W-1:0] hr;
  logic [ADDR_W:0]   len;
  logic              vs_line;
  logic              hs_prev;
  logic              line_start;
  logic              hr_wrap;

  logic [8:0]        rd_q;
  logic              hs_q;
  logic              vs_q;

  // A falling edge on hsync_in only counts on a sampled pixel.
  assign line_start = ce_pix & hs_prev & ~hsync_in;
  assign hr_wrap    = ({1'b0, hr} == (len - 1'b1));

  // Line-buffer write port; the pixel carrying the falling edge closes the old line.
  always_ff @(posedge clk) begin
    if (ce_pix) mem[{wbank, hw}] <= {ri, gi, bi};
  end

  // Line-buffer read port, always from the bank that is not being written.
  always_ff @(posedge clk) begin
    rd_q <= mem[{~wbank, hr}];
  end

  // Write-side address, bank toggle, line-length measurement and delayed vsync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hw      <= '0;
      wbank   <= 1'b0;
      len     <= LEN_RST;
      vs_line <= 1'b1;
      hs_prev <= 1'b1;
    end else if (ce_pix) begin
      hs_prev <= hsync_in;
      if (line_start) begin
        // hw saturates at DEPTH-1, so hw+1 in ADDR_W+1 bits tops out at DEPTH.
        len     <= {1'b0, hw} + 1'b1;
        hw      <= '0;
        wbank   <= ~wbank;
        vs_line <= vsync_in;
      end else if (hw != HW_MAX) begin
        hw <= hw + 1'b1;
      end
    end
  end

  // Read-side pixel counter; a line start restarts it ahead of any wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hr <= '0;
    end else if (line_start || hr_wrap) begin
      hr <= '0;
    end else begin
      hr <= hr + 1'b1;
    end
  end

  // Sync pipeline stage that lines up with the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      hs_q <= ({1'b0, hr} >= HS_LEN);
      vs_q <= vs_line;
    end
  end

`ifdef SCANDOUBLER_SCANLINES_EN
  logic second;
  logic second_q;

  // Copy tracker: 0 on the first output copy of a line, 1 on the second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      second   <= 1'b0;
      second_q <= 1'b0;
    end else begin
      second_q <= second;
      if (line_start) second <= 1'b0;
      else if (hr_wrap) second <= ~second;
    end
  end

  // Output register; the second copy is dimmed by halving each component.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ro    <= '0;
      go    <= '0;
      bo    <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      ro    <= second_q ? {1'b0, rd_q[8:7]} : rd_q[8:6];
      go    <= second_q ? {1'b0, rd_q[5:4]} : rd_q[5:3];
      bo    <= second_q ? {1'b0, rd_q[2:1]} : rd_q[2:0];
      hsync <= hs_q;
      vsync <= vs_q;
    end
  end
`else
  // Output register; both copies of a line are identical.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ro    <= '0;
      go    <= '0;
      bo    <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      ro    <= rd_q[8:6];
      go    <= rd_q[5:3];
      bo    <= rd_q[2:0];
      hsync <= hs_q;
      vsync <= vs_q;
    end
  end
`endif

endmodule
